// File: rtl/vram_dma.sv
// vram_dma: copies a byte block from CPU address space into VRAM, writing only
// while vblank_i is high. One source read and one VRAM write per cycle once the
// pipeline is full; a 2-entry FIFO absorbs the read that is in flight when
// vblank_i drops.
//
// Optional feature macro: VRAM_DMA_FILL_EN. When defined, adds fill_i and
// fill_data_i; a fill transfer writes the latched byte without any source reads.
//
// Ports:
//   cpu_clk, rst            clock, asynchronous active-high reset
//   start_i                 one-cycle start pulse (ignored unless idle)
//   src_addr_i, dst_addr_i  source / VRAM start addresses
//   len_i                   byte count (0 completes immediately)
//   vblank_i                VRAM write window
//   mem_ren_o, mem_address_o, mem_rdata_i   source read port (1-cycle latency)
//   vram_address_o, vram_wdata_o, vram_wen_o VRAM write port
//   busy_o, done_o          status; done_o is a one-cycle completion pulse
module vram_dma #(
    parameter int unsigned LEN_W = 11,
    parameter int unsigned SRC_W = 16
) (
    input  logic             cpu_clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [SRC_W-1:0] src_addr_i,
    input  logic [11:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             vblank_i,
`ifdef VRAM_DMA_FILL_EN
    input  logic             fill_i,
    input  logic [7:0]       fill_data_i,
`endif
    output logic             mem_ren_o,
    output logic [SRC_W-1:0] mem_address_o,
    input  logic [7:0]       mem_rdata_i,
    output logic [11:0]      vram_address_o,
    output logic [7:0]       vram_wdata_o,
    output logic             vram_wen_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state, state_next;
    logic [SRC_W-1:0] src_ptr;
    logic [11:0]      dst_ptr;
    logic [LEN_W-1:0] rd_left, wr_left;
    logic             rd_inflight;
    logic [7:0]       fifo_mem [2];
    logic             fifo_wr_ptr, fifo_rd_ptr;
    logic [1:0]       fifo_count;
    logic [2:0]       occupancy;
    logic             fill_mode;
    logic             push, pop, launch;

`ifdef VRAM_DMA_FILL_EN
    logic       fill_r;
    logic [7:0] fill_byte;

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            fill_r    <= 1'b0;
            fill_byte <= 8'h00;
        end else if (launch) begin
            fill_r    <= fill_i;
            fill_byte <= fill_data_i;
        end
    end

    assign fill_mode    = fill_r;
    assign vram_wdata_o = fill_r ? fill_byte : fifo_mem[fifo_rd_ptr];
`else
    assign fill_mode    = 1'b0;
    assign vram_wdata_o = fifo_mem[fifo_rd_ptr];
`endif

    assign launch         = (state == StIdle) && start_i;
    assign mem_address_o  = src_ptr;
    assign vram_address_o = dst_ptr;
    // Data returns the cycle after the read strobe and is queued unconditionally.
    assign push           = rd_inflight;
    assign pop            = vram_wen_o && !fill_mode;

    always_comb begin
        state_next = state;
        mem_ren_o  = 1'b0;
        vram_wen_o = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        // Bytes that will occupy the FIFO next cycle if no read is issued now.
        occupancy  = {1'b0, fifo_count} + {2'b00, rd_inflight};
        unique case (state)
            StIdle: begin
                if (start_i) begin
                    state_next = (len_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                busy_o     = 1'b1;
                vram_wen_o = vblank_i && (fill_mode || (fifo_count != 2'd0));
                occupancy  = occupancy - {2'b00, vram_wen_o};
                mem_ren_o  = !fill_mode && vblank_i && (rd_left != '0) && (occupancy < 3'd2);
                if (vram_wen_o && (wr_left == LEN_W'(1))) begin
                    state_next = StDone;
                end
            end
            StDone: begin
                busy_o     = 1'b1;
                done_o     = 1'b1;
                state_next = StIdle;
            end
            default: state_next = StIdle;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            src_ptr     <= '0;
            dst_ptr     <= '0;
            rd_left     <= '0;
            wr_left     <= '0;
            rd_inflight <= 1'b0;
        end else begin
            state       <= state_next;
            rd_inflight <= mem_ren_o;
            if (launch) begin
                src_ptr <= src_addr_i;
                dst_ptr <= dst_addr_i;
                rd_left <= len_i;
                wr_left <= len_i;
            end else begin
                if (mem_ren_o) begin
                    src_ptr <= src_ptr + SRC_W'(1);
                    rd_left <= rd_left - LEN_W'(1);
                end
                if (vram_wen_o) begin
                    dst_ptr <= dst_ptr + 12'd1;
                    wr_left <= wr_left - LEN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            fifo_mem[0] <= 8'h00;
            fifo_mem[1] <= 8'h00;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wr_ptr] <= mem_rdata_i;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_dma.sv
// Self-checking bench for vram_dma: directed copy, zero-length, vblank gating,
// destination wrap, mid-transfer reset and (with VRAM_DMA_FILL_EN) fill mode.
module tb_vram_dma;

    logic        cpu_clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [15:0] src_addr_i;
    logic [11:0] dst_addr_i;
    logic [10:0] len_i;
    logic        vblank_i;
    logic        mem_ren_o;
    logic [15:0] mem_address_o;
    logic [7:0]  mem_rdata_i;
    logic [11:0] vram_address_o;
    logic [7:0]  vram_wdata_o;
    logic        vram_wen_o;
    logic        busy_o;
    logic        done_o;
`ifdef VRAM_DMA_FILL_EN
    logic        fill_i;
    logic [7:0]  fill_data_i;
`endif

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;

    logic [11:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    int          wr_cyc_q[$];
    int          bad_wen;
    int          ren_cnt;
    int          first_ren_cyc;
    int          done_cnt;
    int          done_cyc;
    int          start_cyc;
    logic [3:0]  vb_pat = 4'b1001;

    vram_dma #(.LEN_W(11), .SRC_W(16)) dut (
        .cpu_clk        (cpu_clk),
        .rst            (rst),
        .start_i        (start_i),
        .src_addr_i     (src_addr_i),
        .dst_addr_i     (dst_addr_i),
        .len_i          (len_i),
        .vblank_i       (vblank_i),
`ifdef VRAM_DMA_FILL_EN
        .fill_i         (fill_i),
        .fill_data_i    (fill_data_i),
`endif
        .mem_ren_o      (mem_ren_o),
        .mem_address_o  (mem_address_o),
        .mem_rdata_i    (mem_rdata_i),
        .vram_address_o (vram_address_o),
        .vram_wdata_o   (vram_wdata_o),
        .vram_wen_o     (vram_wen_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 cpu_clk = ~cpu_clk;

    always @(posedge cpu_clk) cyc++;

    // Source memory contents: a fixed table at 0x1000, a simple pattern elsewhere.
    function automatic logic [7:0] src_byte(input logic [15:0] a);
        case (a)
            16'h1000: return 8'h11;
            16'h1001: return 8'h22;
            16'h1002: return 8'h33;
            16'h1003: return 8'h44;
            default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    // Synchronous source memory: data valid the cycle after the read strobe.
    always @(posedge cpu_clk) begin
        if (mem_ren_o) mem_rdata_i <= src_byte(mem_address_o);
    end

    // Log bus activity mid-cycle, away from the active edge.
    always @(negedge cpu_clk) begin
        if (vram_wen_o) begin
            wr_addr_q.push_back(vram_address_o);
            wr_data_q.push_back(vram_wdata_o);
            wr_cyc_q.push_back(cyc);
            if (!vblank_i) bad_wen++;
        end
        if (mem_ren_o) begin
            ren_cnt++;
            if (first_ren_cyc < 0) first_ren_cyc = cyc;
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        bad_wen       = 0;
        ren_cnt       = 0;
        first_ren_cyc = -1;
        done_cnt      = 0;
        done_cyc      = -1;
    endtask

    task automatic do_start(input logic [15:0] src, input logic [11:0] dst,
                            input logic [10:0] len);
        clear_log();
        @(posedge cpu_clk); #1;
        start_i    = 1'b1;
        src_addr_i = src;
        dst_addr_i = dst;
        len_i      = len;
        start_cyc  = cyc;
        @(posedge cpu_clk); #1;
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, input bit toggle, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge cpu_clk); #1;
            if (toggle) vblank_i = vb_pat[i % 4];
            if (done_cnt != 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        vblank_i = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        tests_run++;
        if ({mem_ren_o, vram_wen_o, busy_o, done_o, mem_address_o, vram_address_o,
             vram_wdata_o} !== 45'd0) begin
            fails++;
            $display("FAIL reset_outputs: got ren=%b wen=%b busy=%b done=%b maddr=%h vaddr=%h wdata=%h, want all 0",
                     mem_ren_o, vram_wen_o, busy_o, done_o, mem_address_o, vram_address_o, vram_wdata_o);
        end
        @(posedge cpu_clk); #1;
        rst = 1'b0;
        clear_log();
        repeat (3) @(posedge cpu_clk);
        #1;
        tests_run++;
        if (busy_o !== 1'b0 || ren_cnt != 0 || wr_addr_q.size() != 0) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%b reads=%0d writes=%0d, want 0/0/0",
                     busy_o, ren_cnt, wr_addr_q.size());
        end
    endtask

    task automatic test_copy();
        logic [7:0] exp_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        bit to;
        do_start(16'h1000, 12'h400, 11'd4);
        tests_run++;
        if (busy_o !== 1'b1) begin
            fails++;
            $display("FAIL copy_busy: got %b want 1", busy_o);
        end
        wait_done(50, 1'b0, to);
        tests_run++;
        if (to) begin
            fails++;
            $display("FAIL copy_timeout: done_o not seen, want done within 50 cycles");
        end
        tests_run++;
        if (wr_addr_q.size() != 4 || ren_cnt != 4) begin
            fails++;
            $display("FAIL copy_count: writes=%0d reads=%0d, want 4/4", wr_addr_q.size(), ren_cnt);
        end
        for (int i = 0; i < wr_addr_q.size() && i < 4; i++) begin
            tests_run++;
            if (wr_addr_q[i] !== 12'h400 + 12'(i) || wr_data_q[i] !== exp_data[i]) begin
                fails++;
                $display("FAIL copy_write%0d: got %h<=%h want %h<=%h", i, wr_addr_q[i],
                         wr_data_q[i], 12'h400 + 12'(i), exp_data[i]);
            end
        end
        if (wr_cyc_q.size() == 4) begin
            tests_run++;
            if (first_ren_cyc != start_cyc + 1 || wr_cyc_q[0] - first_ren_cyc != 2) begin
                fails++;
                $display("FAIL copy_latency: first read at +%0d, first write %0d after read, want +1 and 2",
                         first_ren_cyc - start_cyc, wr_cyc_q[0] - first_ren_cyc);
            end
            tests_run++;
            if (wr_cyc_q[3] - wr_cyc_q[0] != 3) begin
                fails++;
                $display("FAIL copy_rate: 4 writes span %0d cycles, want 3",
                         wr_cyc_q[3] - wr_cyc_q[0]);
            end
        end
        repeat (2) @(posedge cpu_clk);
        #1;
        tests_run++;
        if (done_cnt != 1 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL copy_done: pulses=%0d busy=%b, want 1 and 0", done_cnt, busy_o);
        end
    endtask

    task automatic test_zero_len();
        bit to;
        do_start(16'h1000, 12'h400, 11'd0);
        wait_done(10, 1'b0, to);
        repeat (2) @(posedge cpu_clk);
        #1;
        tests_run++;
        if (to || ren_cnt != 0 || wr_addr_q.size() != 0 || done_cnt != 1) begin
            fails++;
            $display("FAIL zero_len: timeout=%b reads=%0d writes=%0d dones=%0d, want 0/0/0/1",
                     to, ren_cnt, wr_addr_q.size(), done_cnt);
        end
        // The start cycle is the first; done_o is high in the second.
        tests_run++;
        if (done_cyc - start_cyc != 1) begin
            fails++;
            $display("FAIL zero_len_timing: done %0d cycles after start cycle, want 1",
                     done_cyc - start_cyc);
        end
    endtask

    task automatic test_vblank_gaps();
        bit to;
        int errs = 0;
        do_start(16'h2000, 12'h200, 11'd16);
        wait_done(200, 1'b1, to);
        tests_run++;
        if (to || wr_addr_q.size() != 16 || ren_cnt != 16) begin
            fails++;
            $display("FAIL vblank_count: timeout=%b writes=%0d reads=%0d, want 0/16/16",
                     to, wr_addr_q.size(), ren_cnt);
        end
        for (int i = 0; i < wr_addr_q.size() && i < 16; i++) begin
            if (wr_addr_q[i] !== 12'h200 + 12'(i) ||
                wr_data_q[i] !== src_byte(16'h2000 + 16'(i))) errs++;
        end
        tests_run++;
        if (errs != 0) begin
            fails++;
            $display("FAIL vblank_data: %0d bad writes, want 0", errs);
        end
        tests_run++;
        if (bad_wen != 0) begin
            fails++;
            $display("FAIL vblank_gate: %0d writes with vblank low, want 0", bad_wen);
        end
    endtask

    task automatic test_dst_wrap();
        bit to;
        logic [11:0] exp_addr [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        do_start(16'h3000, 12'hFFE, 11'd4);
        wait_done(50, 1'b0, to);
        tests_run++;
        if (to || wr_addr_q.size() != 4) begin
            fails++;
            $display("FAIL wrap_count: timeout=%b writes=%0d, want 0/4", to, wr_addr_q.size());
        end
        for (int i = 0; i < wr_addr_q.size() && i < 4; i++) begin
            tests_run++;
            if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== src_byte(16'h3000 + 16'(i))) begin
                fails++;
                $display("FAIL wrap_write%0d: got %h<=%h want %h<=%h", i, wr_addr_q[i],
                         wr_data_q[i], exp_addr[i], src_byte(16'h3000 + 16'(i)));
            end
        end
    endtask

    task automatic test_mid_reset();
        bit to;
        bit reached = 1'b0;
        do_start(16'h4000, 12'h500, 11'd8);
        for (int i = 0; i < 50; i++) begin
            if (wr_addr_q.size() >= 3) begin
                reached = 1'b1;
                break;
            end
            @(posedge cpu_clk); #1;
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (!reached || {mem_ren_o, vram_wen_o, busy_o, done_o} !== 4'b0000) begin
            fails++;
            $display("FAIL midreset_outputs: reached=%b ren=%b wen=%b busy=%b done=%b, want 1/0/0/0/0",
                     reached, mem_ren_o, vram_wen_o, busy_o, done_o);
        end
        repeat (2) @(posedge cpu_clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge cpu_clk);
        #1;
        tests_run++;
        if (done_cnt != 0 || wr_addr_q.size() != 3) begin
            fails++;
            $display("FAIL midreset_abandon: dones=%0d writes=%0d, want 0/3", done_cnt,
                     wr_addr_q.size());
        end
        do_start(16'h1002, 12'h600, 11'd2);
        wait_done(50, 1'b0, to);
        tests_run++;
        if (to || wr_addr_q.size() != 2 || wr_addr_q[0] !== 12'h600 || wr_data_q[0] !== 8'h33 ||
            wr_addr_q[1] !== 12'h601 || wr_data_q[1] !== 8'h44) begin
            fails++;
            $display("FAIL midreset_restart: timeout=%b writes=%0d, want 0/2 writing 600<=33 601<=44",
                     to, wr_addr_q.size());
        end
    endtask

`ifdef VRAM_DMA_FILL_EN
    task automatic test_fill();
        bit to;
        int errs = 0;
        fill_i      = 1'b1;
        fill_data_i = 8'h00;
        do_start(16'h1000, 12'h400, 11'd960);
        wait_done(1200, 1'b0, to);
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[i] !== 12'h400 + 12'(i) || wr_data_q[i] !== 8'h00) errs++;
        end
        tests_run++;
        if (to || wr_addr_q.size() != 960 || errs != 0 || ren_cnt != 0) begin
            fails++;
            $display("FAIL fill_clear: timeout=%b writes=%0d bad=%0d reads=%0d, want 0/960/0/0",
                     to, wr_addr_q.size(), errs, ren_cnt);
        end
        fill_data_i = 8'hA5;
        do_start(16'h1000, 12'hFFF, 11'd3);
        wait_done(20, 1'b0, to);
        tests_run++;
        if (to || wr_addr_q.size() != 3 || wr_cyc_q[0] != start_cyc + 1 ||
            wr_addr_q[2] !== 12'h001 || wr_data_q[1] !== 8'hA5 || ren_cnt != 0) begin
            fails++;
            $display("FAIL fill_short: timeout=%b writes=%0d reads=%0d, want 0/3/0 from start+1 ending at 001 with A5",
                     to, wr_addr_q.size(), ren_cnt);
        end
        fill_i = 1'b0;
    endtask
`endif

    initial begin
        start_i     = 1'b0;
        src_addr_i  = '0;
        dst_addr_i  = '0;
        len_i       = '0;
        vblank_i    = 1'b1;
        mem_rdata_i = 8'h00;
`ifdef VRAM_DMA_FILL_EN
        fill_i      = 1'b0;
        fill_data_i = 8'h00;
`endif
        clear_log();
        test_reset();
        test_copy();
        test_zero_len();
        test_vblank_gaps();
        test_dst_wrap();
        test_mid_reset();
`ifdef VRAM_DMA_FILL_EN
        test_fill();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
